// File: rtl/aer_event_scheduler.sv
// AER event scheduler: pairs row (Y) and column (X) words into events
// and queues them for the RAVENS spike input over valid/ready.
module aer_event_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [9:0]                    aer_word,
  input  logic                          aer_word_valid,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_x,
  output logic [8:0]                    ev_y,
  output logic                          ev_pol,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              overflow_count,
  output logic [CNT_W-1:0]              orphan_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] SAT = '1;

  typedef enum logic {
    NO_ROW,
    ROW_VALID
  } state_t;

  state_t state, state_n;

  logic [8:0]    row, row_n;
  logic [17:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count, count_n;
  logic [17:0]   wdata, head_n;
  logic          x_word, y_word, full, pop;
  logic          push, drop, orphan;

  assign x_word     = en & aer_word_valid & ~aer_word[0];
  assign y_word     = en & aer_word_valid & aer_word[0];
  assign full       = (count == FULL);
  assign ev_valid   = (count != '0);
  assign pop        = ev_valid & ev_ready;
  assign wdata      = {aer_word[9:2], row, aer_word[1]};
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) state <= NO_ROW;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    push    = 1'b0;
    drop    = 1'b0;
    orphan  = 1'b0;
    if (!en) begin
      state_n = NO_ROW;
    end else begin
      unique case (state)
        NO_ROW: begin
          orphan = x_word;
          if (y_word) begin
            row_n   = aer_word[9:1];
            state_n = ROW_VALID;
          end
        end
        ROW_VALID: begin
          if (y_word) row_n = aer_word[9:1];
          push = x_word & (~full | pop);
          drop = x_word & full & ~pop;
        end
        default: state_n = NO_ROW;
      endcase
    end
  end

  // A push landing on the next head slot must bypass the array read
  assign rd_nxt  = pop ? rd_ptr + PW'(1) : rd_ptr;
  assign count_n = count + CW'(push) - CW'(pop);
  assign head_n  = (push && wr_ptr == rd_nxt) ? wdata : mem[rd_nxt];

  always_ff @(posedge clk) begin
    if (rst) begin
      row            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      ev_x           <= '0;
      ev_y           <= '0;
      ev_pol         <= 1'b0;
      overflow_count <= '0;
      orphan_count   <= '0;
    end else begin
      row    <= row_n;
      rd_ptr <= rd_nxt;
      count  <= count_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (count_n != '0) {ev_x, ev_y, ev_pol} <= head_n;
      if (drop && overflow_count != SAT)
        overflow_count <= overflow_count + 1'b1;
      if (orphan && orphan_count != SAT)
        orphan_count <= orphan_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: tb/tb_aer_event_scheduler.sv
// Bench for aer_event_scheduler: event-level reference model feeding a
// scoreboard, checked by a monitor at the falling clock edge.
module tb_aer_event_scheduler;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [9:0]  aer_word = '0;
  logic        aer_word_valid = 1'b0;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [7:0]  ev_x;
  logic [8:0]  ev_y;
  logic        ev_pol;
  logic [3:0]  fifo_count;
  logic [CW-1:0] overflow_count;
  logic [CW-1:0] orphan_count;

  aer_event_scheduler #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .aer_word(aer_word),
    .aer_word_valid(aer_word_valid),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_x(ev_x),
    .ev_y(ev_y),
    .ev_pol(ev_pol),
    .fifo_count(fifo_count),
    .overflow_count(overflow_count),
    .orphan_count(orphan_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: events as {x,y,pol}, occupancy as an integer
  logic [17:0] sb[$];
  int   mcount = 0;
  int   m_ovf = 0;
  int   m_orph = 0;
  bit   have_row = 0;
  int   m_row = 0;
  int   last_head = 0;
  bit   started = 0;

  always @(posedge clk) begin
    bit do_pop;
    bit do_push;
    if (rst) begin
      started   = 1;
      mcount    = 0;
      sb.delete();
      m_ovf     = 0;
      m_orph    = 0;
      have_row  = 0;
      m_row     = 0;
      last_head = 0;
    end else begin
      do_pop  = (mcount > 0) && ev_ready;
      do_push = 0;
      if (en && aer_word_valid) begin
        if (aer_word[0]) begin
          m_row    = int'(aer_word[9:1]);
          have_row = 1;
        end else if (!have_row) begin
          if (m_orph < MAXC) m_orph++;
        end else if (mcount == DEPTH && !do_pop) begin
          if (m_ovf < MAXC) m_ovf++;
        end else begin
          sb.push_back({aer_word[9:2], 9'(m_row), aer_word[1]});
          do_push = 1;
        end
      end
      if (!en) have_row = 0;
      mcount = mcount - int'(do_pop) + int'(do_push);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ev_valid", int'(ev_valid), int'(mcount != 0));
      chk("fifo_count", int'(fifo_count), mcount);
      chk("overflow_count", int'(overflow_count), m_ovf);
      chk("orphan_count", int'(orphan_count), m_orph);
      if (ev_valid) begin
        if (sb.size() == 0) begin
          chk("scoreboard_nonempty", 0, 1);
        end else begin
          chk("head", int'({ev_x, ev_y, ev_pol}), int'(sb[0]));
          if (ev_ready) last_head = int'(sb.pop_front());
        end
      end else begin
        chk("hold_when_empty", int'({ev_x, ev_y, ev_pol}), last_head);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [9:0] w);
    aer_word = w;
    aer_word_valid = 1'b1;
    tick();
    aer_word_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [9:0] xw(input int col, input bit pol);
    return {8'(col), pol, 1'b0};
  endfunction

  initial begin
    en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ev_valid", int'(ev_valid), 0);
    chk("reset_head", int'({ev_x, ev_y, ev_pol}), 0);
    chk("reset_fifo_count", int'(fifo_count), 0);

    // Basic event
    do_reset();
    word(10'h00B);
    word(10'h00C);
    chk("t1_valid", int'(ev_valid), 1);
    chk("t1_x", int'(ev_x), 3);
    chk("t1_y", int'(ev_y), 5);
    chk("t1_pol", int'(ev_pol), 0);
    ev_ready = 1'b1;
    tick();
    chk("t1_empty", int'(fifo_count), 0);
    ev_ready = 1'b0;

    // Orphan, then extreme addresses
    do_reset();
    word(10'h012);
    chk("t2_orphan", int'(orphan_count), 1);
    chk("t2_no_event", int'(ev_valid), 0);
    word(10'h3FF);
    word(10'h3FE);
    chk("t2_x", int'(ev_x), 255);
    chk("t2_y", int'(ev_y), 511);
    chk("t2_pol", int'(ev_pol), 1);

    // Overflow then ordered drain
    do_reset();
    word(10'h00F);
    for (int c = 0; c < 10; c++) word(xw(c, c[0]));
    chk("t3_full", int'(fifo_count), 8);
    chk("t3_overflow", int'(overflow_count), 2);
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("t3_drained", int'(ev_valid), 0);
    chk("t3_last_x", int'(ev_x), 7);
    ev_ready = 1'b0;

    // Full with simultaneous push and pop
    do_reset();
    word(10'h00F);
    for (int c = 0; c < 8; c++) word(xw(c, 1'b0));
    ev_ready = 1'b1;
    word(xw(20, 1'b1));
    ev_ready = 1'b0;
    chk("t4_count", int'(fifo_count), 8);
    chk("t4_overflow", int'(overflow_count), 0);
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("t4_last_x", int'(ev_x), 20);
    chk("t4_last_pol", int'(ev_pol), 1);
    ev_ready = 1'b0;

    // Disable keeps draining but ignores input and drops the row
    do_reset();
    word(10'h009);
    for (int c = 0; c < 3; c++) word(xw(c + 40, 1'b1));
    en = 1'b0;
    word(xw(99, 1'b0));
    chk("t5_count", int'(fifo_count), 3);
    chk("t5_orphan0", int'(orphan_count), 0);
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_drained", int'(ev_valid), 0);
    ev_ready = 1'b0;
    en = 1'b1;
    word(xw(5, 1'b0));
    chk("t5_orphan1", int'(orphan_count), 1);
    chk("t5_no_event", int'(ev_valid), 0);

    // Reset mid-operation
    do_reset();
    word(10'h005);
    for (int c = 0; c < 4; c++) word(xw(c, 1'b1));
    ev_ready = 1'b1;
    do_reset();
    chk("t6_valid", int'(ev_valid), 0);
    chk("t6_count", int'(fifo_count), 0);
    chk("t6_orphan0", int'(orphan_count), 0);
    ev_ready = 1'b0;
    word(xw(6, 1'b0));
    chk("t6_orphan1", int'(orphan_count), 1);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) word(xw(i, 1'b0));
    chk("sat_orphan", int'(orphan_count), MAXC);
    word(10'h001);
    for (int i = 0; i < 30; i++) word(xw(i, 1'b1));
    chk("sat_overflow", int'(overflow_count), MAXC);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en             = ($urandom_range(0, 15) != 0);
      aer_word_valid = $urandom_range(0, 1) == 1;
      aer_word       = 10'($urandom);
      aer_word[0]    = ($urandom_range(0, 3) == 0);
      ev_ready       = (i < 750) ? ($urandom_range(0, 2) == 0)
                                 : ($urandom_range(0, 2) != 0);
      rst            = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    aer_word_valid = 1'b0;
    ev_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("final_empty", int'(ev_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
